// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: operation codes, the queued
// command record and the returned response record.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD = 4'h0,
    SUB = 4'h1,
    AND = 4'h2,
    OR  = 4'h3,
    NOP = 4'hF
  } alu_op_e;

  // op stays a raw code: undefined codes are legal and must reach the ALU unchanged.
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [3:0] tag;
  } alu_cmd_t;

  typedef struct packed {
    logic [7:0] result;
    logic       carry;
    logic [3:0] tag;
  } alu_rsp_t;

endpackage

// File: rtl/alu_cmd_sequencer_fifo.sv
// Synchronous FIFO with (log2(DEPTH)+1)-bit pointers; full/empty come from
// the pointer MSB compare, so all status is registered-pointer based.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign do_push = push_i & (~full_o | pop_i) & ~flush_i;
  assign do_pop  = pop_i & ~empty_o;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= wr_ptr_q;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are valid, and leaving the array unreset keeps it plain RAM.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, issues one per cycle to a registered external ALU and
// returns {result, carry, tag} in acceptance order through a response FIFO.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [3:0] cmd_op,
  input  logic [3:0] cmd_tag,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic       alu_carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_carry,
  output logic [3:0] rsp_tag,
  input  logic       flush,
  output logic       busy
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  alu_cmd_t    cmd_in, cmd_head;
  alu_rsp_t    rsp_in, rsp_head;
  logic        cmd_full, cmd_empty, cmd_push;
  logic        rsp_empty, rsp_pop, rsp_full_unused;
  logic [AW:0] cmd_count, rsp_count;
  logic        credit_ok, issue;
  logic        issued_q;
  logic [3:0]  tag_q;

  assign cmd_in    = '{a: cmd_a, b: cmd_b, op: cmd_op, tag: cmd_tag};
  assign cmd_ready = ~cmd_full & ~flush;
  assign cmd_push  = cmd_valid & cmd_ready;

  // Reserve a response slot for every command in flight so captures never drop.
  assign credit_ok = (rsp_count + {{AW{1'b0}}, issued_q}) < DEPTH_C;
  assign issue     = ~cmd_empty & ~flush & credit_ok;

  sync_fifo #(.WIDTH($bits(alu_cmd_t)), .DEPTH(DEPTH)) u_cmd_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush_i (flush),
    .push_i  (cmd_push),
    .pop_i   (issue),
    .wdata_i (cmd_in),
    .rdata_o (cmd_head),
    .full_o  (cmd_full),
    .empty_o (cmd_empty),
    .count_o (cmd_count)
  );

  // NOTE: every output of this block gets a default before the conditional,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = NOP;
    if (issue) begin
      alu_a   = cmd_head.a;
      alu_b   = cmd_head.b;
      alu_sel = cmd_head.op;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issued_q <= 1'b0;
      tag_q    <= '0;
    end else begin
      issued_q <= issue;
      if (issue) tag_q <= cmd_head.tag;
    end
  end

  assign rsp_in  = '{result: alu_out, carry: alu_carry, tag: tag_q};
  assign rsp_pop = rsp_valid & rsp_ready;

  sync_fifo #(.WIDTH($bits(alu_rsp_t)), .DEPTH(DEPTH)) u_rsp_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush_i (1'b0),
    .push_i  (issued_q),
    .pop_i   (rsp_pop),
    .wdata_i (rsp_in),
    .rdata_o (rsp_head),
    .full_o  (rsp_full_unused),
    .empty_o (rsp_empty),
    .count_o (rsp_count)
  );

  // Outputs are gated so an empty queue presents zeros rather than stale RAM.
  assign rsp_valid  = ~rsp_empty;
  assign rsp_result = rsp_valid ? rsp_head.result : '0;
  assign rsp_carry  = rsp_valid ? rsp_head.carry  : 1'b0;
  assign rsp_tag    = rsp_valid ? rsp_head.tag    : '0;

  assign busy = (cmd_count != '0) | issued_q | rsp_valid;

endmodule
